// File: rtl/data_array_pkg.sv
// rtl/data_array_pkg.sv - shared types, widths and byte-mask helper for the data array controller
package data_array_pkg;
   localparam int IDX_W  = 5;
   localparam int LINE_W = 128;
   localparam int WORD_W = 32;
   localparam int BEATS  = LINE_W / WORD_W;

   typedef enum logic [1:0] {IDLE, FILL, WRLINE} dac_state_e;

   // Active-low bit enables: only the strobed bytes of word 'off' are written.
   function automatic logic [LINE_W-1:0] strb_to_bweb(input logic [1:0] off, input logic [3:0] strb);
      logic [LINE_W-1:0] mask;
      mask = '1;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) mask[int'(off)*WORD_W + b*8 +: 8] = 8'h00;
      end
      return mask;
   endfunction
endpackage

// File: rtl/data_array_ctrl_if.sv
// rtl/data_array_ctrl_if.sv - core access and refill beat bus of the data array controller
interface data_array_ctrl_if;
   import data_array_pkg::*;

   logic              core_req;
   logic              core_we;
   logic [IDX_W-1:0]  core_idx;
   logic              core_way;
   logic [1:0]        core_off;
   logic [WORD_W-1:0] core_wdata;
   logic [3:0]        core_wstrb;
   logic              core_gnt;
   logic              core_rvalid;
   logic [WORD_W-1:0] core_rdata;
   logic              rf_valid;
   logic [IDX_W-1:0]  rf_idx;
   logic              rf_way;
   logic [WORD_W-1:0] rf_data;
   logic              rf_ready;
   logic              rf_done;

   modport master (
      output core_req, core_we, core_idx, core_way, core_off, core_wdata, core_wstrb,
      output rf_valid, rf_idx, rf_way, rf_data,
      input  core_gnt, core_rvalid, core_rdata, rf_ready, rf_done
   );

   modport slave (
      input  core_req, core_we, core_idx, core_way, core_off, core_wdata, core_wstrb,
      input  rf_valid, rf_idx, rf_way, rf_data,
      output core_gnt, core_rvalid, core_rdata, rf_ready, rf_done
   );
endinterface

// File: rtl/dac_line_buf.sv
// rtl/dac_line_buf.sv - refill beat buffer: word slots filled in order by a wrapping write pointer
module dac_line_buf
   import data_array_pkg::*;
#(
   parameter int CNT_W = $clog2(BEATS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [WORD_W-1:0] wr_data,
   output logic [CNT_W-1:0]  count,
   output logic [LINE_W-1:0] line
);
   logic [WORD_W-1:0] words [BEATS];

   // Pointer wraps to 0 after the last beat, ready for the next line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) count <= '0;
      else if (wr_en) count <= count + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_en) words[count] <= wr_data;
   end

   always_comb begin
      line = '0;
      for (int i = 0; i < BEATS; i++) line[i*WORD_W +: WORD_W] = words[i];
   end
endmodule

// File: rtl/data_array_ctrl.sv
// rtl/data_array_ctrl.sv - arbitrates core word accesses and refill line writes onto one SRAM port
// Optional macro DATA_ARRAY_CTRL_STATS_EN adds saturating read/write/stall counters.
module data_array_ctrl
   import data_array_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   data_array_ctrl_if.slave  bus,
   output logic [IDX_W-1:0]  sram_A,
   output logic [LINE_W-1:0] sram_DI,
   output logic              sram_WEB,
   output logic [LINE_W-1:0] sram_BWEB,
   output logic              sram_CEB,
   output logic              sram_WAY,
   input  logic [LINE_W-1:0] sram_DO
`ifdef DATA_ARRAY_CTRL_STATS_EN
   ,
   output logic [31:0]       stat_rd,
   output logic [31:0]       stat_wr,
   output logic [31:0]       stat_stall
`endif
);
   localparam int CNT_W = $clog2(BEATS);

   dac_state_e        state, next_state;
   logic [CNT_W-1:0]  beat_cnt;
   logic [LINE_W-1:0] line;
   logic [IDX_W-1:0]  fill_idx;
   logic              fill_way;
   logic              beat_acc;
   logic              conflict;
   logic [1:0]        off_q;

   assign bus.rf_ready = (state != WRLINE);
   assign beat_acc     = bus.rf_valid && bus.rf_ready;

   dac_line_buf #(.CNT_W(CNT_W)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (beat_acc),
      .wr_data (bus.rf_data),
      .count   (beat_cnt),
      .line    (line)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (beat_acc) next_state = FILL;
         FILL:    if (beat_acc && beat_cnt == CNT_W'(BEATS-1)) next_state = WRLINE;
         WRLINE:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_idx <= '0;
         fill_way <= 1'b0;
      end else if (state == IDLE && beat_acc) begin
         fill_idx <= bus.rf_idx;
         fill_way <= bus.rf_way;
      end
   end

   // The line being filled is stale in the SRAM until its write lands.
   assign conflict     = (state == FILL) && (bus.core_idx == fill_idx) && (bus.core_way == fill_way);
   assign bus.core_gnt = bus.core_req && (state != WRLINE) && !conflict;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rf_done     <= 1'b0;
         bus.core_rvalid <= 1'b0;
         off_q           <= '0;
      end else begin
         bus.rf_done     <= (state == WRLINE);
         bus.core_rvalid <= bus.core_gnt && !bus.core_we;
         if (bus.core_gnt) off_q <= bus.core_off;
      end
   end

   assign bus.core_rdata = bus.core_rvalid ? sram_DO[off_q*WORD_W +: WORD_W] : '0;

   always_comb begin
      sram_CEB  = 1'b1;
      sram_WEB  = 1'b1;
      sram_BWEB = '1;
      sram_A    = '0;
      sram_DI   = '0;
      sram_WAY  = 1'b0;
      if (state == WRLINE) begin
         sram_CEB  = 1'b0;
         sram_WEB  = 1'b0;
         sram_BWEB = '0;
         sram_DI   = line;
         sram_A    = fill_idx;
         sram_WAY  = fill_way;
      end else if (bus.core_gnt) begin
         sram_CEB = 1'b0;
         sram_A   = bus.core_idx;
         sram_WAY = bus.core_way;
         if (bus.core_we) begin
            sram_WEB  = 1'b0;
            sram_DI   = {BEATS{bus.core_wdata}};
            sram_BWEB = strb_to_bweb(bus.core_off, bus.core_wstrb);
         end
      end
   end

`ifdef DATA_ARRAY_CTRL_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_rd    <= '0;
         stat_wr    <= '0;
         stat_stall <= '0;
      end else begin
         if (bus.core_gnt && !bus.core_we && stat_rd != '1) stat_rd <= stat_rd + 1'b1;
         if (bus.core_gnt && bus.core_we && stat_wr != '1) stat_wr <= stat_wr + 1'b1;
         if (bus.core_req && !bus.core_gnt && stat_stall != '1) stat_stall <= stat_stall + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_data_array_ctrl.sv
// tb/tb_data_array_ctrl.sv - self-checking bench for data_array_ctrl with a behavioural SRAM and word model
module tb_data_array_ctrl;
   import data_array_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   data_array_ctrl_if bus ();

   logic [IDX_W-1:0]  sram_A;
   logic [LINE_W-1:0] sram_DI, sram_BWEB, sram_DO;
   logic              sram_WEB, sram_CEB, sram_WAY;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int wr_cnt = 0;
   logic clear_mem = 1'b0;

   logic [LINE_W-1:0] sram_mem [2][32];
   logic [WORD_W-1:0] exp_mem [2][32][4];

   data_array_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .sram_A    (sram_A),
      .sram_DI   (sram_DI),
      .sram_WEB  (sram_WEB),
      .sram_BWEB (sram_BWEB),
      .sram_CEB  (sram_CEB),
      .sram_WAY  (sram_WAY),
      .sram_DO   (sram_DO)
   );

   // Wrapper model: bit-masked write, one-cycle read latency.
   always @(posedge clk) begin
      if (clear_mem) begin
         for (int w = 0; w < 2; w++)
            for (int i = 0; i < 32; i++) sram_mem[w][i] <= '0;
         sram_DO <= '0;
      end else if (!sram_CEB) begin
         if (!sram_WEB)
            sram_mem[sram_WAY][sram_A] <= (sram_mem[sram_WAY][sram_A] & sram_BWEB) | (sram_DI & ~sram_BWEB);
         else
            sram_DO <= sram_mem[sram_WAY][sram_A];
      end
   end

   always @(negedge clk) begin
      if (bus.rf_done) done_cnt <= done_cnt + 1;
      if (!sram_CEB && !sram_WEB) wr_cnt <= wr_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   task automatic idle_in();
      bus.core_req = 0; bus.core_we = 0; bus.core_idx = '0; bus.core_way = 0; bus.core_off = '0;
      bus.core_wdata = '0; bus.core_wstrb = '0;
      bus.rf_valid = 0; bus.rf_idx = '0; bus.rf_way = 0; bus.rf_data = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_in();
      clear_mem = 1'b1;
      for (int w = 0; w < 2; w++)
         for (int i = 0; i < 32; i++)
            for (int o = 0; o < 4; o++) exp_mem[w][i][o] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.core_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %0h want 0", bus.core_gnt); end
      checks++; if (bus.core_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0h want 0", bus.core_rvalid); end
      checks++; if (bus.core_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %0h want 0", bus.core_rdata); end
      checks++; if (bus.rf_done !== 1'b0) begin errors++; $display("FAIL reset_rf_done got %0h want 0", bus.rf_done); end
      checks++; if (bus.rf_ready !== 1'b1) begin errors++; $display("FAIL reset_rf_ready got %0h want 1", bus.rf_ready); end
      checks++; if (sram_CEB !== 1'b1 || sram_WEB !== 1'b1) begin errors++; $display("FAIL reset_ceb_web got %0h/%0h want 1/1", sram_CEB, sram_WEB); end
      checks++; if (sram_BWEB !== {LINE_W{1'b1}}) begin errors++; $display("FAIL reset_bweb got %0h want all ones", sram_BWEB); end
      checks++; if (sram_A !== '0 || sram_DI !== '0 || sram_WAY !== 1'b0) begin errors++; $display("FAIL reset_addr_data got A=%0h DI=%0h WAY=%0h want 0", sram_A, sram_DI, sram_WAY); end
      clear_mem = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic test_refill(input logic [IDX_W-1:0] idx, input logic way, input logic [LINE_W-1:0] line);
      int d0, w0;
      d0 = done_cnt; w0 = wr_cnt;
      for (int b = 0; b < 4; b++) begin
         @(posedge clk); #1;
         bus.rf_valid = 1'b1;
         bus.rf_idx   = (b == 0) ? idx : ~idx;
         bus.rf_way   = (b == 0) ? way : ~way;
         bus.rf_data  = line[b*WORD_W +: WORD_W];
         @(negedge clk);
         checks++; if (bus.rf_ready !== 1'b1) begin errors++; $display("FAIL refill_ready beat %0d got %0h want 1", b, bus.rf_ready); end
      end
      @(posedge clk); #1; bus.rf_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.rf_ready !== 1'b0) begin errors++; $display("FAIL wrline_ready got %0h want 0", bus.rf_ready); end
      checks++; if (sram_CEB !== 1'b0 || sram_WEB !== 1'b0 || sram_BWEB !== '0) begin errors++; $display("FAIL wrline_ctl got CEB=%0h WEB=%0h BWEB=%0h want 0/0/0", sram_CEB, sram_WEB, sram_BWEB); end
      checks++; if (sram_A !== idx || sram_WAY !== way) begin errors++; $display("FAIL wrline_addr got A=%0h WAY=%0h want A=%0h WAY=%0h", sram_A, sram_WAY, idx, way); end
      checks++; if (sram_DI !== line) begin errors++; $display("FAIL wrline_di got %0h want %0h", sram_DI, line); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus.rf_done !== 1'b1) begin errors++; $display("FAIL rf_done_pulse got %0h want 1", bus.rf_done); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus.rf_done !== 1'b0) begin errors++; $display("FAIL rf_done_clear got %0h want 0", bus.rf_done); end
      checks++; if (done_cnt - d0 != 1 || wr_cnt - w0 != 1) begin errors++; $display("FAIL refill_counts got done=%0d writes=%0d want 1/1", done_cnt - d0, wr_cnt - w0); end
      for (int b = 0; b < 4; b++) exp_mem[way][idx][b] = line[b*WORD_W +: WORD_W];
   endtask

   task automatic test_core_read(input logic [IDX_W-1:0] idx, input logic way, input logic [1:0] off, input int exp_wait);
      int n;
      @(posedge clk); #1;
      bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_idx = idx; bus.core_way = way; bus.core_off = off;
      @(negedge clk);
      n = 0;
      while (bus.core_gnt !== 1'b1 && n < 20) begin @(posedge clk); @(negedge clk); n++; end
      checks++; if (bus.core_gnt !== 1'b1 || (exp_wait >= 0 && n != exp_wait)) begin errors++; $display("FAIL read_gnt got gnt=%0h wait=%0d want 1 wait=%0d", bus.core_gnt, n, exp_wait); end
      checks++; if (sram_CEB !== 1'b0 || sram_WEB !== 1'b1 || sram_A !== idx || sram_WAY !== way) begin errors++; $display("FAIL read_ctl got CEB=%0h WEB=%0h A=%0h WAY=%0h", sram_CEB, sram_WEB, sram_A, sram_WAY); end
      @(posedge clk); #1; bus.core_req = 1'b0;
      @(negedge clk);
      checks++; if (bus.core_rvalid !== 1'b1) begin errors++; $display("FAIL read_rvalid got %0h want 1", bus.core_rvalid); end
      checks++; if (bus.core_rdata !== exp_mem[way][idx][off]) begin errors++; $display("FAIL read_data idx=%0d way=%0d off=%0d got %08h want %08h", idx, way, off, bus.core_rdata, exp_mem[way][idx][off]); end
   endtask

   task automatic test_core_write(input logic [IDX_W-1:0] idx, input logic way, input logic [1:0] off,
                                  input logic [WORD_W-1:0] wdata, input logic [3:0] strb);
      logic [LINE_W-1:0] exp_bweb;
      int n;
      exp_bweb = '1;
      for (int k = 0; k < 16; k++)
         if (k / 4 == int'(off) && strb[k % 4]) exp_bweb[k*8 +: 8] = 8'h00;
      @(posedge clk); #1;
      bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_idx = idx; bus.core_way = way; bus.core_off = off;
      bus.core_wdata = wdata; bus.core_wstrb = strb;
      @(negedge clk);
      n = 0;
      while (bus.core_gnt !== 1'b1 && n < 20) begin @(posedge clk); @(negedge clk); n++; end
      checks++; if (bus.core_gnt !== 1'b1) begin errors++; $display("FAIL write_gnt got %0h want 1", bus.core_gnt); end
      checks++; if (sram_CEB !== 1'b0 || sram_WEB !== 1'b0 || sram_A !== idx || sram_WAY !== way) begin errors++; $display("FAIL write_ctl got CEB=%0h WEB=%0h A=%0h WAY=%0h", sram_CEB, sram_WEB, sram_A, sram_WAY); end
      checks++; if (sram_DI !== {wdata, wdata, wdata, wdata}) begin errors++; $display("FAIL write_di got %0h want 4x %08h", sram_DI, wdata); end
      checks++; if (sram_BWEB !== exp_bweb) begin errors++; $display("FAIL write_bweb got %0h want %0h", sram_BWEB, exp_bweb); end
      @(posedge clk); #1; bus.core_req = 1'b0; bus.core_we = 1'b0;
      for (int b = 0; b < 4; b++)
         if (strb[b]) exp_mem[way][idx][off][b*8 +: 8] = wdata[b*8 +: 8];
   endtask

   task automatic test_conflict();
      logic [LINE_W-1:0] line;
      line = {$urandom, $urandom, $urandom, $urandom};
      for (int b = 0; b < 4; b++) begin
         @(posedge clk); #1;
         bus.rf_valid = 1'b1; bus.rf_idx = 5'd7; bus.rf_way = 1'b0; bus.rf_data = line[b*WORD_W +: WORD_W];
         if (b == 1) begin
            bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_idx = 5'd7; bus.core_way = 1'b0; bus.core_off = 2'd3;
         end
         @(negedge clk);
         if (b > 0) begin
            checks++; if (bus.core_gnt !== 1'b0) begin errors++; $display("FAIL conflict_fill_gnt beat %0d got %0h want 0", b, bus.core_gnt); end
         end
      end
      @(posedge clk); #1; bus.rf_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.core_gnt !== 1'b0) begin errors++; $display("FAIL conflict_wrline_gnt got %0h want 0", bus.core_gnt); end
      for (int b = 0; b < 4; b++) exp_mem[0][7][b] = line[b*WORD_W +: WORD_W];
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus.core_gnt !== 1'b1 || bus.rf_done !== 1'b1) begin errors++; $display("FAIL conflict_release got gnt=%0h done=%0h want 1/1", bus.core_gnt, bus.rf_done); end
      @(posedge clk); #1; bus.core_req = 1'b0;
      @(negedge clk);
      checks++; if (bus.core_rdata !== exp_mem[0][7][3] || bus.core_rvalid !== 1'b1) begin errors++; $display("FAIL conflict_data got %08h want %08h", bus.core_rdata, exp_mem[0][7][3]); end
      // Other way of the same set proceeds in parallel with the fill.
      line = {$urandom, $urandom, $urandom, $urandom};
      for (int b = 0; b < 4; b++) begin
         @(posedge clk); #1;
         bus.rf_valid = 1'b1; bus.rf_idx = 5'd7; bus.rf_way = 1'b0; bus.rf_data = line[b*WORD_W +: WORD_W];
         bus.core_req = (b == 1); bus.core_we = 1'b0; bus.core_idx = 5'd7; bus.core_way = 1'b1; bus.core_off = 2'd1;
         @(negedge clk);
         if (b == 1) begin
            checks++; if (bus.core_gnt !== 1'b1) begin errors++; $display("FAIL parallel_gnt got %0h want 1", bus.core_gnt); end
         end
         if (b == 2) begin
            checks++; if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== exp_mem[1][7][1]) begin errors++; $display("FAIL parallel_data got v=%0h %08h want %08h", bus.core_rvalid, bus.core_rdata, exp_mem[1][7][1]); end
         end
      end
      @(posedge clk); #1; bus.rf_valid = 1'b0; bus.core_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int b = 0; b < 4; b++) exp_mem[0][7][b] = line[b*WORD_W +: WORD_W];
   endtask

   task automatic test_wrline_stall();
      logic [LINE_W-1:0] line;
      line = {$urandom, $urandom, $urandom, $urandom};
      for (int b = 0; b < 4; b++) begin
         @(posedge clk); #1;
         bus.rf_valid = 1'b1; bus.rf_idx = 5'd9; bus.rf_way = 1'b1; bus.rf_data = line[b*WORD_W +: WORD_W];
      end
      @(posedge clk); #1;
      bus.rf_valid = 1'b0;
      bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_idx = 5'd3; bus.core_way = 1'b0; bus.core_off = 2'd0;
      @(negedge clk);
      checks++; if (bus.core_gnt !== 1'b0 || sram_A !== 5'd9 || sram_WEB !== 1'b0) begin errors++; $display("FAIL stall_wrline got gnt=%0h A=%0h WEB=%0h want 0/9/0", bus.core_gnt, sram_A, sram_WEB); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus.core_gnt !== 1'b1) begin errors++; $display("FAIL stall_retry_gnt got %0h want 1", bus.core_gnt); end
      @(posedge clk); #1; bus.core_req = 1'b0;
      @(negedge clk);
      checks++; if (bus.core_rdata !== exp_mem[0][3][0]) begin errors++; $display("FAIL stall_data got %08h want %08h", bus.core_rdata, exp_mem[0][3][0]); end
      for (int b = 0; b < 4; b++) exp_mem[1][9][b] = line[b*WORD_W +: WORD_W];
   endtask

   task automatic test_reset_midfill();
      int d0, w0;
      d0 = done_cnt; w0 = wr_cnt;
      for (int b = 0; b < 2; b++) begin
         @(posedge clk); #1;
         bus.rf_valid = 1'b1; bus.rf_idx = 5'd12; bus.rf_way = 1'b0; bus.rf_data = $urandom;
      end
      @(posedge clk); #1; bus.rf_valid = 1'b0;
      #2 rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.rf_ready !== 1'b1 || sram_CEB !== 1'b1) begin errors++; $display("FAIL midfill_reset got ready=%0h CEB=%0h want 1/1", bus.rf_ready, sram_CEB); end
      @(posedge clk); #1; rst = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      checks++; if (done_cnt != d0 || wr_cnt != w0) begin errors++; $display("FAIL midfill_no_write got done=%0d writes=%0d want 0/0", done_cnt - d0, wr_cnt - w0); end
   endtask

   task automatic test_random();
      logic [IDX_W-1:0] idx;
      logic way;
      logic [1:0] off;
      for (int i = 0; i < 40; i++) begin
         idx = IDX_W'($urandom_range(0, 31));
         way = 1'($urandom_range(0, 1));
         off = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0, 1, 2: test_core_read(idx, way, off, 0);
            3, 4:    test_core_write(idx, way, off, $urandom, 4'($urandom_range(0, 15)));
            default: test_refill(idx, way, {$urandom, $urandom, $urandom, $urandom});
         endcase
      end
   endtask

   initial begin
      test_reset();
      test_refill(5'd5, 1'b1, 128'h44444444_33333333_22222222_11111111);
      test_core_read(5'd5, 1'b1, 2'd2, 0);
      test_core_write(5'd5, 1'b1, 2'd1, 32'hAABBCCDD, 4'b0101);
      test_core_read(5'd5, 1'b1, 2'd1, 0);
      test_core_write(5'd5, 1'b1, 2'd3, 32'h12345678, 4'b0000);
      test_core_read(5'd5, 1'b1, 2'd3, 0);
      test_conflict();
      test_wrline_stall();
      test_reset_midfill();
      test_refill(5'd12, 1'b0, {$urandom, $urandom, $urandom, $urandom});
      test_core_read(5'd12, 1'b0, 2'd2, 0);
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
